// File: rtl/lsu_mem_port.sv
// lsu_mem_port
// Load/store front end between the CPU memory stage and a byte-enabled,
// word-organised data RAM with one-cycle synchronous read latency.
// Computes byte-lane enables, lane-shifts store data, splits accesses that
// straddle a word boundary into two beats, merges and sign/zero-extends load
// data, and stalls the pipeline until the access completes.
//
// Optional feature: define MISALIGNED_EN to split word-crossing accesses into
// two beats. Without it, crossing accesses are suppressed (no lanes, no write,
// load returns 0) but still take single-beat timing and pulse misaligned.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid, req_we    request strobe (held while stall=1), store select
//   LS_mode              access size/sign (B/H/W/UB/UH mode defines)
//   a, wd                byte address, right-aligned store data
//   stall                hold the pipeline, access not finished this cycle
//   rd, rd_valid         extended load result and its qualifier
//   misaligned           one-cycle pulse when a crossing access is accepted
//   mem_addr, mem_byteena, mem_wd, mem_we   RAM request
//   mem_q                RAM read data for the previous cycle's address

`ifndef B_MODE
`define B_MODE  3'd0
`endif
`ifndef H_MODE
`define H_MODE  3'd1
`endif
`ifndef W_MODE
`define W_MODE  3'd2
`endif
`ifndef UB_MODE
`define UB_MODE 3'd4
`endif
`ifndef UH_MODE
`define UH_MODE 3'd5
`endif

module lsu_mem_port #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            LS_mode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] wd,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_valid,
  output logic                  misaligned,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [3:0]            mem_byteena,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

`ifdef MISALIGNED_EN
  localparam bit split_en = 1'b1;
`else
  localparam bit split_en = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;

  state_t                  state;
  logic [2:0]              l_mode;
  logic [1:0]              l_off;
  logic [MEM_AW-1:0]       l_idx;
  logic [DATA_WIDTH-1:0]   l_wd;
  logic                    l_we;
  logic [3:0]              l_hi;
  logic                    l_ok;
  logic                    l_split;
  logic [DATA_WIDTH-1:0]   hold;

  logic [1:0]              off;
  logic [MEM_AW-1:0]       word_idx;
  logic [3:0]              size_mask;
  logic [7:0]              lanes;
  logic                    req_cross;
  logic                    req_ok;
  logic                    accept;
  logic [1:0]              inv_off;
  logic [2*DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_addr_bits;

  assign off              = a[1:0];
  assign word_idx         = a[MEM_AW+1:2];
  assign unused_addr_bits = ^a[DATA_WIDTH-1:MEM_AW+2];

  // Size mask right-aligned at lane 0; unknown modes get no lanes at all.
  always_comb begin
    size_mask = 4'b0000;
    case (LS_mode)
      `B_MODE, `UB_MODE: size_mask = 4'b0001;
      `H_MODE, `UH_MODE: size_mask = 4'b0011;
      `W_MODE:           size_mask = 4'b1111;
      default:           size_mask = 4'b0000;
    endcase
  end

  // Shifting into an 8-lane window puts beat-0 lanes in [3:0] and the
  // lanes that spill into the next word in [7:4].
  assign lanes     = {4'b0000, size_mask} << off;
  assign req_cross = |lanes[7:4];
  assign req_ok    = (size_mask != 4'b0000) && (!req_cross || split_en);
  assign accept    = (state == IDLE) && req_valid;

  // For off in 1..3 this yields 4-off, the right shift for the spilled bytes.
  assign inv_off   = 2'd0 - l_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      l_mode  <= 3'd0;
      l_off   <= 2'd0;
      l_idx   <= '0;
      l_wd    <= '0;
      l_we    <= 1'b0;
      l_hi    <= 4'b0000;
      l_ok    <= 1'b0;
      l_split <= 1'b0;
      hold    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_mode  <= LS_mode;
            l_off   <= off;
            l_idx   <= word_idx;
            l_wd    <= wd;
            l_we    <= req_we;
            l_hi    <= lanes[7:4];
            l_ok    <= req_ok;
            l_split <= req_cross && req_ok;
            if (req_cross && req_ok)
              state <= SECOND;
            else if (!req_we)
              state <= RESP;
          end
        end
        SECOND: begin
          // mem_q now holds the first beat's word; keep it for the merge.
          hold  <= mem_q;
          state <= l_we ? IDLE : RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM request: beat 0 straight from the live request, beat 1 from the
  // latched copy; everything else leaves the RAM port quiet.
  always_comb begin
    mem_addr    = '0;
    mem_byteena = 4'b0000;
    mem_wd      = '0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          mem_addr = word_idx;
          mem_wd   = wd << {off, 3'b000};
          if (req_ok) begin
            mem_byteena = lanes[3:0];
            mem_we      = req_we;
          end
        end
      end
      SECOND: begin
        mem_addr    = l_idx + MEM_AW'(1);
        mem_byteena = l_hi;
        mem_wd      = l_wd >> {inv_off, 3'b000};
        mem_we      = l_we;
      end
      default: ;
    endcase
  end

  // Only the final store beat releases the pipeline without a response cycle.
  assign stall      = (accept && (!req_we || (req_cross && req_ok)))
                    || ((state == SECOND) && !l_we);
  assign misaligned = accept && req_cross;

  // Load merge: the two beats form a 64-bit window shifted down by the byte
  // offset, then the access size selects how much survives and how to extend.
  assign pair   = l_split ? {mem_q, hold} : {{DATA_WIDTH{1'b0}}, mem_q};
  assign merged = DATA_WIDTH'(pair >> {l_off, 3'b000});

  always_comb begin
    rd_valid = (state == RESP);
    rd       = '0;
    if ((state == RESP) && l_ok) begin
      case (l_mode)
        `B_MODE:  rd = {{(DATA_WIDTH-8){merged[7]}}, merged[7:0]};
        `UB_MODE: rd = {{(DATA_WIDTH-8){1'b0}}, merged[7:0]};
        `H_MODE:  rd = {{(DATA_WIDTH-16){merged[15]}}, merged[15:0]};
        `UH_MODE: rd = {{(DATA_WIDTH-16){1'b0}}, merged[15:0]};
        `W_MODE:  rd = merged;
        default:  rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port
// Self-checking bench for lsu_mem_port. A behavioural byte-enabled RAM with
// one-cycle read latency sits on the memory port. A vector table drives
// loads and stores; expected load results go into a scoreboard queue when a
// load is issued and are popped when rd_valid appears. Hand-written sequences
// cover beat-level port values, index wrap and reset during a second beat.
// Expectations follow whether MISALIGNED_EN is defined for this build.

`ifndef B_MODE
`define B_MODE  3'd0
`endif
`ifndef H_MODE
`define H_MODE  3'd1
`endif
`ifndef W_MODE
`define W_MODE  3'd2
`endif
`ifndef UB_MODE
`define UB_MODE 3'd4
`endif
`ifndef UH_MODE
`define UH_MODE 3'd5
`endif

module tb_lsu_mem_port;

`ifdef MISALIGNED_EN
  localparam bit split = 1'b1;
`else
  localparam bit split = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  ls_mode;
  logic [31:0] a;
  logic [31:0] wd;
  logic        stall;
  logic [31:0] rd;
  logic        rd_valid;
  logic        misaligned;
  logic [14:0] mem_addr;
  logic [3:0]  mem_byteena;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] ram [0:32767];
  logic        pre_en;
  logic [14:0] pre_addr;
  logic [31:0] pre_data;

  int num_checks;
  int num_errors;
  logic [31:0] exp_q [$];

  int          ncyc;
  logic [14:0] b_addr  [0:2];
  logic [3:0]  b_be    [0:2];
  logic [31:0] b_wd    [0:2];
  logic        b_we    [0:2];
  logic        b_mis   [0:2];

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_cycles;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [19];

  lsu_mem_port #(.DATA_WIDTH(32), .MEM_AW(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .LS_mode     (ls_mode),
    .a           (a),
    .wd          (wd),
    .stall       (stall),
    .rd          (rd),
    .rd_valid    (rd_valid),
    .misaligned  (misaligned),
    .mem_addr    (mem_addr),
    .mem_byteena (mem_byteena),
    .mem_wd      (mem_wd),
    .mem_we      (mem_we),
    .mem_q       (mem_q)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: byte-lane writes, registered read, plus a preload port
  // so the bench can seed contents without a second driver on the array.
  always @(posedge clk) begin
    if (pre_en)
      ram[pre_addr] <= pre_data;
    else if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i]) ram[mem_addr][8*i +: 8] <= mem_wd[8*i +: 8];
    mem_q <= ram[mem_addr];
  end

  // Hard stop in case something wedges the flow.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [14:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Drives one request, holds it while stall=1, records each beat and
  // scores any load result against the queue.
  task automatic applyStimulus(input string tag, input logic we_i, input logic [2:0] mode_i,
                               input logic [31:0] a_i, input logic [31:0] wd_i,
                               input logic [31:0] exp_rd_i);
    bit done;
    logic [31:0] e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we_i; ls_mode = mode_i; a = a_i; wd = wd_i;
    if (!we_i) exp_q.push_back(exp_rd_i);
    for (int k = 0; k < 3; k++) begin
      b_addr[k] = '0; b_be[k] = '0; b_wd[k] = '0; b_we[k] = 1'b0; b_mis[k] = 1'b0;
    end
    ncyc = 0;
    done = 1'b0;
    while (!done && ncyc < 6) begin
      @(negedge clk);
      if (ncyc < 3) begin
        b_addr[ncyc] = mem_addr; b_be[ncyc] = mem_byteena; b_wd[ncyc] = mem_wd;
        b_we[ncyc] = mem_we; b_mis[ncyc] = misaligned;
      end
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          num_checks++; num_errors++;
          $display("[TB] FAIL %s unexpected rd_valid: got rd %h, expected no result", tag, rd);
        end else begin
          e = exp_q.pop_front();
          checkOutput({tag, " rd"}, rd, e);
        end
      end
      if (!stall) done = 1'b1;
      ncyc++;
    end
    if (!done) begin
      num_checks++; num_errors++;
      $display("[TB] FAIL %s stall timeout: got %0d cycles, expected release", tag, ncyc);
    end
    if (!we_i) checkOutput({tag, " pending results"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; ls_mode = `W_MODE; a = '0; wd = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    num_checks = 0; num_errors = 0;

    vecs[0]  = '{1'b0, `W_MODE,  32'h102, 32'h0, split ? 32'h66554433 : 32'h0, split ? 3 : 2, 1'b1};
    vecs[1]  = '{1'b0, `B_MODE,  32'h143, 32'h0, 32'hFFFFFF80, 2, 1'b0};
    vecs[2]  = '{1'b0, `UB_MODE, 32'h143, 32'h0, 32'h00000080, 2, 1'b0};
    vecs[3]  = '{1'b0, `H_MODE,  32'h142, 32'h0, 32'hFFFF80C0, 2, 1'b0};
    vecs[4]  = '{1'b0, `UH_MODE, 32'h140, 32'h0, 32'h0000A0B0, 2, 1'b0};
    vecs[5]  = '{1'b0, `W_MODE,  32'h180, 32'h0, 32'h12345678, 2, 1'b0};
    vecs[6]  = '{1'b0, `B_MODE,  32'h180, 32'h0, 32'h00000078, 2, 1'b0};
    vecs[7]  = '{1'b1, `W_MODE,  32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0};
    vecs[8]  = '{1'b0, `W_MODE,  32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0};
    vecs[9]  = '{1'b1, `B_MODE,  32'h181, 32'h0000005A, 32'h0, 1, 1'b0};
    vecs[10] = '{1'b0, `W_MODE,  32'h180, 32'h0, 32'h12345A78, 2, 1'b0};
    vecs[11] = '{1'b1, `H_MODE,  32'h103, 32'h0000ABCD, 32'h0, split ? 2 : 1, 1'b1};
    vecs[12] = '{1'b0, `W_MODE,  32'h100, 32'h0, split ? 32'hCDADBEEF : 32'hDEADBEEF, 2, 1'b0};
    vecs[13] = '{1'b0, `W_MODE,  32'h104, 32'h0, split ? 32'h887766AB : 32'h88776655, 2, 1'b0};
    vecs[14] = '{1'b0, `UH_MODE, 32'h103, 32'h0, split ? 32'h0000ABCD : 32'h0, split ? 3 : 2, 1'b1};
    vecs[15] = '{1'b0, `H_MODE,  32'h103, 32'h0, split ? 32'hFFFFABCD : 32'h0, split ? 3 : 2, 1'b1};
    vecs[16] = '{1'b0, 3'd7,     32'h100, 32'h0, 32'h0, 2, 1'b0};
    vecs[17] = '{1'b1, 3'd7,     32'h180, 32'hFFFFFFFF, 32'h0, 1, 1'b0};
    vecs[18] = '{1'b0, `W_MODE,  32'h180, 32'h0, 32'h12345A78, 2, 1'b0};

    // Reset state, including the idle memory port.
    @(negedge clk);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset rd", rd, 32'd0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset misaligned", 32'(misaligned), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset mem_byteena", 32'(mem_byteena), 32'd0);
    checkOutput("reset mem_wd", mem_wd, 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);

    poke(15'h40, 32'h44332211);
    poke(15'h41, 32'h88776655);
    poke(15'h50, 32'h80C0A0B0);
    poke(15'h60, 32'h12345678);
    poke(15'h7FFF, 32'h00005555);
    poke(15'h0000, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle mem_byteena", 32'(mem_byteena), 32'd0);
    checkOutput("idle mem_we", 32'(mem_we), 32'd0);

    // Table-driven accesses.
    for (int i = 0; i < 19; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i].we, vecs[i].mode, vecs[i].addr,
                    vecs[i].data, vecs[i].exp_rd);
      checkOutput($sformatf("v%0d cycles", i), 32'(ncyc), 32'(vecs[i].exp_cycles));
      checkOutput($sformatf("v%0d misaligned", i), 32'(b_mis[0]), 32'(vecs[i].exp_mis));
    end

    // Aligned word store: single beat, full lanes, no stall.
    applyStimulus("st_w", 1'b1, `W_MODE, 32'h100, 32'hDEADBEEF, 32'h0);
    checkOutput("st_w cycles", 32'(ncyc), 32'd1);
    checkOutput("st_w addr", 32'(b_addr[0]), 32'h40);
    checkOutput("st_w byteena", 32'(b_be[0]), 32'hF);
    checkOutput("st_w wd", b_wd[0], 32'hDEADBEEF);
    checkOutput("st_w we", 32'(b_we[0]), 32'd1);

    // Crossing halfword store at offset 3.
    applyStimulus("st_h", 1'b1, `H_MODE, 32'h103, 32'h0000ABCD, 32'h0);
    checkOutput("st_h misaligned", 32'(b_mis[0]), 32'd1);
    checkOutput("st_h addr0", 32'(b_addr[0]), 32'h40);
    checkOutput("st_h byteena0", 32'(b_be[0]), split ? 32'h8 : 32'h0);
    checkOutput("st_h we0", 32'(b_we[0]), split ? 32'd1 : 32'd0);
    checkOutput("st_h cycles", 32'(ncyc), split ? 32'd2 : 32'd1);
`ifdef MISALIGNED_EN
    checkOutput("st_h wd0", b_wd[0], 32'hCD000000);
    checkOutput("st_h addr1", 32'(b_addr[1]), 32'h41);
    checkOutput("st_h byteena1", 32'(b_be[1]), 32'h1);
    checkOutput("st_h wd1", b_wd[1], 32'h000000AB);
    checkOutput("st_h we1", 32'(b_we[1]), 32'd1);
    checkOutput("st_h misaligned1", 32'(b_mis[1]), 32'd0);
`endif

    // Crossing word load at offset 1.
    applyStimulus("ld_w1", 1'b0, `W_MODE, 32'h101, 32'h0, split ? 32'hABCDADBE : 32'h0);
    checkOutput("ld_w1 cycles", 32'(ncyc), split ? 32'd3 : 32'd2);
    checkOutput("ld_w1 byteena0", 32'(b_be[0]), split ? 32'hE : 32'h0);
    checkOutput("ld_w1 we0", 32'(b_we[0]), 32'd0);
`ifdef MISALIGNED_EN
    checkOutput("ld_w1 byteena1", 32'(b_be[1]), 32'h1);
`endif

    // Crossing store on the last word: wrap of the second beat, then a reset
    // during that beat must drop it while the first beat stays written.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; ls_mode = `W_MODE; a = 32'h0001FFFE; wd = 32'h11223344;
    @(negedge clk);
    checkOutput("wrap addr0", 32'(mem_addr), 32'h7FFF);
    checkOutput("wrap misaligned", 32'(misaligned), 32'd1);
`ifdef MISALIGNED_EN
    checkOutput("wrap byteena0", 32'(mem_byteena), 32'hC);
    checkOutput("wrap wd0", mem_wd, 32'h33440000);
    checkOutput("wrap stall0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    checkOutput("wrap addr1", 32'(mem_addr), 32'h0);
    checkOutput("wrap byteena1", 32'(mem_byteena), 32'h3);
    checkOutput("wrap wd1", mem_wd, 32'h00001122);
    checkOutput("wrap stall1", 32'(stall), 32'd0);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    #1;
    checkOutput("rst2 stall", 32'(stall), 32'd0);
    checkOutput("rst2 mem_byteena", 32'(mem_byteena), 32'd0);
    checkOutput("rst2 mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst2 mem_wd", mem_wd, 32'd0);
    checkOutput("rst2 mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("wrap ram0 untouched", ram[0], 32'hCAFEF00D);
    checkOutput("wrap ram7fff", ram[15'h7FFF], 32'h33445555);
`else
    checkOutput("wrap byteena0", 32'(mem_byteena), 32'h0);
    checkOutput("wrap we0", 32'(mem_we), 32'd0);
    checkOutput("wrap stall0", 32'(stall), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    checkOutput("wrap idle byteena", 32'(mem_byteena), 32'd0);
    checkOutput("wrap ram0 untouched", ram[0], 32'hCAFEF00D);
    checkOutput("wrap ram7fff untouched", ram[15'h7FFF], 32'h00005555);
`endif

    // Reset in the response cycle of a load clears the result at once.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; ls_mode = `W_MODE; a = 32'h180;
    @(negedge clk);
    checkOutput("rst3 stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rst3 rd_valid before", 32'(rd_valid), 32'd1);
    checkOutput("rst3 rd before", rd, 32'h12345A78);
    rst = 1'b1;
    #1;
    checkOutput("rst3 rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst3 rd", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // The unit must accept work normally after the reset.
    applyStimulus("post_rst", 1'b0, `UB_MODE, 32'h143, 32'h0, 32'h00000080);
    checkOutput("post_rst cycles", 32'(ncyc), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store front end between the CPU's memory stage and the byte-enabled, word-organised data RAM (synchronous read, one-cycle latency). Accepts one access per request, computes byte-lane enables, shifts store data into lanes, splits accesses that straddle a word boundary into two word beats, merges and sign/zero-extends returned load data, and stalls the pipeline until the access completes.

## Interface
- DATA_WIDTH, 32, CPU data and address width (fixed at 32 lanes-wise: 4 byte lanes)
- MEM_AW, 15, RAM word-address width; word index = a[MEM_AW+1:2]
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  access requested this cycle; held with all req inputs stable while stall=1
- req_we  in  1  1 = store, 0 = load
- LS_mode  in  3  access size/sign, shared `B_MODE/`H_MODE/`W_MODE/`UB_MODE/`UH_MODE defines
- a  in  DATA_WIDTH  byte address
- wd  in  DATA_WIDTH  store data, right-aligned
- stall  out  1  hold pipeline; request not finished this cycle
- rd  out  DATA_WIDTH  extended load result, valid when rd_valid=1, else 0
- rd_valid  out  1  load result present this cycle
- misaligned  out  1  accepted access crosses a word boundary (one-cycle pulse at acceptance)
- mem_addr  out  MEM_AW  RAM word address
- mem_byteena  out  4  RAM byte-lane enables
- mem_wd  out  DATA_WIDTH  lane-shifted write data
- mem_we  out  1  RAM write enable
- mem_q  in  DATA_WIDTH  RAM read data, for address presented previous cycle

## Operation
- Size: B/UB=1, H/UH=2, W=4 bytes; off=a[1:0]. Crossing iff off+size>4 (W with off≠0, H/UH with off=3). Other LS_mode codes: byteena=0, no write, load returns 0, single-beat timing.
- States: IDLE, SECOND, RESP. Request latched (mode, off, word index, wd, we) on acceptance in IDLE.
- Beat0 (IDLE, req_valid=1): mem_addr=word index, byteena=lanes off..min(3,off+size-1), mem_wd=wd<<8·off, mem_we=req_we.
- Beat1 (SECOND): mem_addr=index+1 (wraps mod 2^MEM_AW), byteena=lanes 0..off+size-5, mem_wd=wd>>8·(4-off), mem_we=latched we.
- Transitions: IDLE→SECOND if crossing; IDLE→RESP if non-crossing load; IDLE→IDLE if non-crossing store. SECOND→RESP if load, →IDLE if store. RESP→IDLE.
- Load merge: beat0 mem_q captured into hold register in SECOND; in RESP form {beat1_q, beat0_q} (non-crossing: {0, q}), shift right 8·off, keep size bytes; sign-extend for B/H, zero-extend UB/UH, W unchanged.
- stall = (IDLE & req_valid & not single-cycle store) | SECOND-with-load; stall=0 in RESP and in the last store beat.
- req_valid ignored outside IDLE. Idle with req_valid=0: all mem_* outputs 0.
- Reset any state → IDLE; pending beat dropped (first beat of crossing store stays written), hold register cleared.

## Timing
- Reset values: stall=0, rd=0, rd_valid=0, misaligned=0, mem_addr=0, mem_byteena=0, mem_wd=0, mem_we=0, state IDLE.
- Aligned store: 1 cycle, no stall. Crossing store: 2 cycles, stall in cycle 1.
- Aligned load: 2 cycles, rd_valid in cycle 2. Crossing load: 3 cycles, rd_valid in cycle 3.
- mem_* outputs combinational from state, latched request and current inputs; rd/rd_valid combinational in RESP from mem_q.
- Back-to-back: next request accepted the cycle after RESP or after last store beat.

## Configuration
- MISALIGNED_EN defined: crossing accesses split as above.
- Not defined: crossing access takes single-beat timing, byteena=0, mem_we=0, load returns rd=0; misaligned still pulses; SECOND unreachable.

## Test plan
- Store W 0xDEADBEEF a=0x100 → one cycle, mem_addr=0x40, byteena=1111, mem_wd=0xDEADBEEF, stall=0.
- Load B a=0x103, RAM word 0x80xxxxxx → cycle 2 rd=0xFFFFFF80, rd_valid=1; UB same → 0x00000080.
- Store H 0xABCD a=0x103 → beat0 addr 0x40 byteena=1000 mem_wd=0xCD000000; beat1 addr 0x41 byteena=0001 mem_wd=0x000000AB; misaligned=1.
- Load W a=0x102, words 0x44332211 @0x40, 0x88776655 @0x41 → cycle 3 rd=0x66554433.
- Crossing store at last word (index 0x7FFF, off=2) → beat1 mem_addr=0x0000; rst asserted in SECOND → immediate IDLE, all outputs 0, beat1 never issued.
- Without MISALIGNED_EN: Load W a=0x101 → rd=0 in cycle 2, no mem_we, byteena=0.
